ddr_rd_burst_master: RTL and testbench

- Consumes the frame-read request (valid/addr/num) from the read address controller. Issues AXI4 read bursts to the DDR controller.
- Forwards returned beats into the read-side pixel FIFO.
- Reports completion through a level done flag. Upstream edge-detects this flag through a 3-flop synchroniser.
- Sits between the read address controller and the AXI read port of the DDR IP, in the DDR clock domain.

---
 rtl/ddr_rd_burst_master.sv | 172 +++++++++++++++++
 tb/tb_ddr_rd_burst_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_burst_master.sv
// ---------------------------------------------------------------------------
// ddr_rd_burst_master
//
// Turns a frame-read request (start address + beat count) into a sequence of
// AXI4 INCR read bursts of at most BURST_LEN beats. Only one burst is in
// flight at a time. Each returned R beat is written into the read-side pixel
// FIFO one cycle later. A new burst is only issued while the FIFO reports
// room for a full burst.
//
// Ports
//   clk, rst             DDR user clock, synchronous active-high reset
//   req_valid/addr/num   request from the read address controller; a request
//                        is taken on a rising edge of req_valid while idle
//   rd_done              level flag, high from completion until next request
//   rd_err               sticky, a non-OKAY rresp was seen in this request
//   fifo_prog_full       FIFO cannot take another BURST_LEN beats
//   fifo_wr_en/wdata     one write per accepted R beat
//   ar*                  AXI4 read address channel (arid/arsize/arburst fixed)
//   r*                   AXI4 read data channel
// ---------------------------------------------------------------------------
module ddr_rd_burst_master #(
    parameter int ADDR_WIDTH   = 30,
    parameter int RD_NUM_WIDTH = 28,
    parameter int DATA_WIDTH   = 256,
    parameter int BURST_LEN    = 16,
    parameter int ID_WIDTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [RD_NUM_WIDTH-1:0] req_num,
    output logic                    rd_done,
    output logic                    rd_err,
    input  logic                    fifo_prog_full,
    output logic                    fifo_wr_en,
    output logic [DATA_WIDTH-1:0]   fifo_wdata,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int SIZE_LOG2  = $clog2(BEAT_BYTES);
    localparam logic [RD_NUM_WIDTH-1:0] BURST_MAX = RD_NUM_WIDTH'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_req_valid_d;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [RD_NUM_WIDTH-1:0] r_remain;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]              r_arlen;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_fifo_wr_en;
    logic [DATA_WIDTH-1:0]   r_fifo_wdata;
    logic                    r_rd_done;
    logic                    r_rd_err;

    logic                    w_req_edge;
    logic [RD_NUM_WIDTH-1:0] w_beats;
    logic [8:0]              w_len_p1;
    logic                    w_beat;

    assign w_req_edge = req_valid & ~r_req_valid_d;
    // Beats in the next burst: the lesser of what is left and BURST_LEN.
    assign w_beats    = (r_remain > BURST_MAX) ? BURST_MAX : r_remain;
    // arlen+1 needs 9 bits when BURST_LEN is 256.
    assign w_len_p1   = {1'b0, r_arlen} + 9'd1;
    // rready is only high in DATA, so this is an accepted beat of our burst.
    assign w_beat     = rvalid & r_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_valid_d <= 1'b0;
            r_cur_addr    <= '0;
            r_remain      <= '0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_fifo_wr_en  <= 1'b0;
            r_fifo_wdata  <= '0;
            r_rd_done     <= 1'b0;
            r_rd_err      <= 1'b0;
        end else begin
            // Edge detector runs in every state so an edge that arrives while
            // busy is consumed and not replayed on return to IDLE.
            r_req_valid_d <= req_valid;
            r_fifo_wr_en  <= w_beat;
            if (w_beat) begin
                r_fifo_wdata <= rdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req_edge) begin
                        r_cur_addr <= req_addr;
                        r_remain   <= req_num;
                        r_rd_done  <= 1'b0;
                        r_rd_err   <= 1'b0;
                        r_state    <= (req_num == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!fifo_prog_full) begin
                        r_araddr  <= r_cur_addr;
                        r_arlen   <= 8'(w_beats - RD_NUM_WIDTH'(1));
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        r_arvalid  <= 1'b0;
                        r_cur_addr <= r_cur_addr + (ADDR_WIDTH'(w_len_p1) << SIZE_LOG2);
                        r_remain   <= r_remain - RD_NUM_WIDTH'(w_len_p1);
                        r_rready   <= 1'b1;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (rresp != 2'b00) begin
                            r_rd_err <= 1'b1;
                        end
                        if (rlast) begin
                            r_rready <= 1'b0;
                            r_state  <= (r_remain == '0) ? S_DONE : S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    r_rd_done <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign arid       = '0;
    assign arsize     = 3'(SIZE_LOG2);
    assign arburst    = 2'b01;
    assign araddr     = r_araddr;
    assign arlen      = r_arlen;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;
    assign fifo_wr_en = r_fifo_wr_en;
    assign fifo_wdata = r_fifo_wdata;
    assign rd_done    = r_rd_done;
    assign rd_err     = r_rd_err;

endmodule

// File: tb/tb_ddr_rd_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_burst_master
//
// Directed bench for ddr_rd_burst_master. A small AXI read slave returns
// beats whose data encodes the beat address, so the FIFO write stream can be
// checked against the request start address. Slave and monitor work on the
// falling edge; stimulus is applied and checked 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_ddr_rd_burst_master;

    localparam int AW = 30;
    localparam int NW = 28;
    localparam int DW = 256;
    localparam int BL = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [NW-1:0] req_num;
    logic          rd_done;
    logic          rd_err;
    logic          fifo_prog_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wdata;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata   = '0;
    logic [1:0]    rresp   = 2'b00;
    logic          rlast   = 1'b0;
    logic          rvalid  = 1'b0;
    logic          rready;

    always #5 clk = ~clk;

    ddr_rd_burst_master #(
        .ADDR_WIDTH(AW), .RD_NUM_WIDTH(NW), .DATA_WIDTH(DW),
        .BURST_LEN(BL), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_num(req_num),
        .rd_done(rd_done), .rd_err(rd_err),
        .fifo_prog_full(fifo_prog_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {(DW/32){32'(a)}};
    endfunction

    // ---- AXI read slave ---------------------------------------------------
    int            stall_cycles = 0;   // arready held low this many cycles per AR
    int            err_at       = -1;  // global beat index answered with SLVERR
    int            ar_stall_cnt = 0;
    int            beats_left   = 0;
    int            beat_total   = 0;
    int            rlast_cyc    = 0;
    int            cyc          = 0;
    logic [AW-1:0] r_addr       = '0;
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            arready      = 1'b0;
            rvalid       = 1'b0;
            rlast        = 1'b0;
            rresp        = 2'b00;
            beats_left   = 0;
            ar_stall_cnt = 0;
        end else begin
            if (beats_left > 0) begin
                rvalid = 1'b1;
                rdata  = pat(r_addr);
                rlast  = (beats_left == 1);
                rresp  = (beat_total == err_at) ? 2'b10 : 2'b00;
                if (beats_left == 1) rlast_cyc = cyc + 1;
                r_addr = r_addr + AW'(32);
                beats_left--;
                beat_total++;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
            if (arvalid) begin
                if (ar_stall_cnt < stall_cycles) begin
                    arready = 1'b0;
                    ar_stall_cnt++;
                end else begin
                    // Handshake completes on the coming rising edge.
                    arready      = 1'b1;
                    ar_stall_cnt = 0;
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(arlen);
                    r_addr       = araddr;
                    beats_left   = int'(arlen) + 1;
                end
            end else begin
                arready = 1'b0;
            end
        end
    end

    // ---- FIFO write monitor -----------------------------------------------
    logic [AW-1:0] base_addr = '0;
    int            wr_base   = 0;
    int            wr_cnt    = 0;
    int            wdata_bad = 0;
    int            done_rise_cyc = 0;
    logic          done_q    = 1'b0;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (fifo_wdata !== pat(base_addr + AW'((wr_cnt - wr_base) * 32))) wdata_bad++;
            wr_cnt++;
        end
        if (rd_done && !done_q) done_rise_cyc = cyc;
        done_q = rd_done;
    end

    // ---- stimulus helpers -------------------------------------------------
    task automatic req(input logic [AW-1:0] a, input logic [NW-1:0] n);
        @(posedge clk); #1;
        req_addr  = a;
        req_num   = n;
        req_valid = 1'b1;
        base_addr = a;
        wr_base   = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        for (int i = 0; i < maxc && !rd_done; i++) begin
            @(posedge clk); #1;
        end
        chk(tag, rd_done, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ab;
        int wb;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        req_num        = '0;
        fifo_prog_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_rready", rready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_done", rd_done, 0);
        chk("rst_err", rd_err, 0);
        chk("arsize", arsize, 5);
        chk("arburst", arburst, 1);
        chk("arid", arid, 0);
        rst = 1'b0;

        // 40 beats -> 16 + 16 + 8
        ab = ar_addr_q.size();
        wb = wr_cnt;
        req(30'h0200_0000, 40);
        wait_done("t1_done", 300);
        chk("t1_ar_n", ar_addr_q.size() - ab, 3);
        chk("t1_ar0_addr", ar_addr_q[ab], 30'h0200_0000);
        chk("t1_ar0_len", ar_len_q[ab], 15);
        chk("t1_ar1_addr", ar_addr_q[ab+1], 30'h0200_0200);
        chk("t1_ar1_len", ar_len_q[ab+1], 15);
        chk("t1_ar2_addr", ar_addr_q[ab+2], 30'h0200_0400);
        chk("t1_ar2_len", ar_len_q[ab+2], 7);
        chk("t1_wr_n", wr_cnt - wb, 40);
        chk("t1_wdata", wdata_bad, 0);
        chk("t1_done_lat", done_rise_cyc - rlast_cyc, 1);
        chk("t1_err", rd_err, 0);

        // zero-length request: straight to done, no AR
        ab = ar_addr_q.size();
        req(30'h0300_0000, 0);
        chk("t2_done_clr", rd_done, 0);
        for (int i = 0; i < 3 && !rd_done; i++) begin
            @(posedge clk); #1;
        end
        chk("t2_done", rd_done, 1);
        chk("t2_no_ar", ar_addr_q.size() - ab, 0);
        chk("t2_arvalid", arvalid, 0);

        // arready held low for 10 cycles
        stall_cycles = 10;
        ab = ar_addr_q.size();
        wb = wr_cnt;
        req(30'h0000_1000, 16);
        for (int i = 0; i < 20 && !arvalid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t3_arvalid", arvalid, 1);
            chk("t3_araddr", araddr, 30'h0000_1000);
            chk("t3_arlen", arlen, 15);
            @(posedge clk); #1;
        end
        wait_done("t3_done", 100);
        stall_cycles = 0;
        chk("t3_ar_n", ar_addr_q.size() - ab, 1);
        chk("t3_wr_n", wr_cnt - wb, 16);

        // prog_full after the first burst holds off the second
        ab = ar_addr_q.size();
        wb = wr_cnt;
        req(30'h0000_4000, 32);
        for (int i = 0; i < 50 && ar_addr_q.size() == ab; i++) begin
            @(posedge clk); #1;
        end
        fifo_prog_full = 1'b1;
        for (int i = 0; i < 100 && (wr_cnt - wb) < 16; i++) begin
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("t4_ar_hold", ar_addr_q.size() - ab, 1);
        chk("t4_arvalid", arvalid, 0);
        chk("t4_wr16", wr_cnt - wb, 16);
        fifo_prog_full = 1'b0;
        wait_done("t4_done", 100);
        chk("t4_ar_n", ar_addr_q.size() - ab, 2);
        chk("t4_ar1_addr", ar_addr_q[ab+1], 30'h0000_4200);
        chk("t4_wr_n", wr_cnt - wb, 32);

        // SLVERR on the fifth beat
        err_at = beat_total + 4;
        req(30'h0000_8000, 16);
        wait_done("t5_done", 100);
        chk("t5_err", rd_err, 1);
        err_at = -1;

        // next request clears err/done; reset lands mid-burst
        wb = wr_cnt;
        req(30'h0000_C000, 16);
        chk("t5_err_clr", rd_err, 0);
        chk("t6_done_clr", rd_done, 0);
        for (int i = 0; i < 50 && (wr_cnt - wb) < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_rready_pre", rready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rready", rready, 0);
        chk("t6_done", rd_done, 0);
        chk("t6_wr_en", fifo_wr_en, 0);
        chk("t6_arvalid", arvalid, 0);
        rst = 1'b0;
        ab = ar_addr_q.size();
        wb = wr_cnt;
        req(30'h0001_0000, 16);
        wait_done("t6_done2", 100);
        chk("t6_ar_n", ar_addr_q.size() - ab, 1);
        chk("t6_ar_addr", ar_addr_q[ab], 30'h0001_0000);
        chk("t6_wr_n", wr_cnt - wb, 16);
        chk("t6_err", rd_err, 0);
        chk("all_wdata", wdata_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
